// File: rtl/hit_vector_pkg.sv
// Shared types and parameter helpers for the hit_vector_scan block.
package hit_vector_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    localparam int TOTAL_W = 32;

    function automatic int calc_nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int calc_idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/hit_chunk_eval.sv
// Combinational evaluation of one scan chunk: popcount, any-hit and the
// lowest/highest set offsets within the chunk.
module hit_chunk_eval #(
    parameter int CHUNK = 16,
    parameter int POP_W = $clog2(CHUNK + 1),
    parameter int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] slice,
    input  logic [CHUNK-1:0] mask,
    output logic [POP_W-1:0] pop,
    output logic             any,
    output logic [OFF_W-1:0] lo,
    output logic [OFF_W-1:0] hi
);

    logic [CHUNK-1:0] live;

    assign live = slice & mask;
    assign any  = |live;

    // Ascending pass leaves the highest set offset; descending pass the lowest.
    always_comb begin
        pop = '0;
        lo  = '0;
        hi  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + POP_W'(live[i]);
            if (live[i]) hi = OFF_W'(i);
        end
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (live[i]) lo = OFF_W'(i);
        end
    end

endmodule

// File: rtl/hit_vector_scan.sv
// Multi-cycle hit vector scanner: CHUNK bits per cycle, LSB first.
// Optional running hit total enabled by defining HIT_VECTOR_ACCUM_EN.
module hit_vector_scan
    import hit_vector_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [calc_cnt_w(WIDTH)-1:0]  out_count,
    output logic [calc_idx_w(WIDTH)-1:0]  out_first,
    output logic [calc_idx_w(WIDTH)-1:0]  out_last,
    output logic                          out_any
`ifdef HIT_VECTOR_ACCUM_EN
    ,
    input  logic                          accum_clr,
    output logic [TOTAL_W-1:0]            total_count
`endif
);

    localparam int NCHUNK    = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W     = calc_cnt_w(WIDTH);
    localparam int IDX_W     = calc_idx_w(WIDTH);
    localparam int PAD_W     = NCHUNK * CHUNK;
    localparam int K_W       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int POP_W     = $clog2(CHUNK + 1);
    localparam int OFF_W     = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int LAST_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_BITS);

    scan_state_t state_q, state_d;

    logic [PAD_W-1:0] shadow;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] cnt_acc;
    logic [IDX_W-1:0] first_acc;
    logic [IDX_W-1:0] last_acc;
    logic             found;

    logic             is_last;
    logic [CHUNK-1:0] chunk_mask;
    logic [POP_W-1:0] chunk_pop;
    logic             chunk_any;
    logic [OFF_W-1:0] chunk_lo;
    logic [OFF_W-1:0] chunk_hi;
    logic [IDX_W-1:0] base;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] first_next;
    logic [IDX_W-1:0] last_next;
    logic             found_next;

    assign is_last    = (k == K_W'(NCHUNK - 1));
    assign chunk_mask = is_last ? LAST_MASK : {CHUNK{1'b1}};
    assign base       = IDX_W'(k * CHUNK);

    hit_chunk_eval #(
        .CHUNK (CHUNK)
    ) u_eval (
        .slice (shadow[CHUNK-1:0]),
        .mask  (chunk_mask),
        .pop   (chunk_pop),
        .any   (chunk_any),
        .lo    (chunk_lo),
        .hi    (chunk_hi)
    );

    assign cnt_next   = cnt_acc + CNT_W'(chunk_pop);
    assign first_next = (chunk_any && !found) ? (base + IDX_W'(chunk_lo)) : first_acc;
    assign last_next  = chunk_any ? (base + IDX_W'(chunk_hi)) : last_acc;
    assign found_next = found | chunk_any;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (is_last)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // The shadow register shifts down so the current chunk always sits at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow    <= '0;
            k         <= '0;
            cnt_acc   <= '0;
            first_acc <= '0;
            last_acc  <= '0;
            found     <= 1'b0;
            out_count <= '0;
            out_first <= '0;
            out_last  <= '0;
            out_any   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shadow    <= PAD_W'(in_vec);
                        k         <= '0;
                        cnt_acc   <= '0;
                        first_acc <= '0;
                        last_acc  <= '0;
                        found     <= 1'b0;
                    end
                end
                SCAN: begin
                    shadow    <= shadow >> CHUNK;
                    k         <= k + K_W'(1);
                    cnt_acc   <= cnt_next;
                    first_acc <= first_next;
                    last_acc  <= last_next;
                    found     <= found_next;
                    if (is_last) begin
                        out_count <= cnt_next;
                        out_first <= first_next;
                        out_last  <= last_next;
                        out_any   <= found_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HIT_VECTOR_ACCUM_EN
    localparam int SUM_W = TOTAL_W + 1;

    logic [SUM_W-1:0] total_sum;

    assign total_sum = {1'b0, total_count} + SUM_W'(out_count);

    // A clear on the same edge as a result handshake drops that result.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_count <= '0;
        end else if (accum_clr) begin
            total_count <= '0;
        end else if (out_valid && out_ready) begin
            total_count <= total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_hit_vector_scan.sv
// Directed self-checking bench for hit_vector_scan (64/16 and 40/16 instances).
module tb_hit_vector_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_any;
    logic [63:0] in_vec;
    logic [6:0]  out_count;
    logic [5:0]  out_first, out_last;

    logic        in_valid40, in_ready40, out_valid40, out_ready40, out_any40;
    logic [39:0] in_vec40;
    logic [5:0]  out_count40;
    logic [5:0]  out_first40, out_last40;

`ifdef HIT_VECTOR_ACCUM_EN
    logic        accum_clr, accum_clr40;
    logic [31:0] total_count, total_count40;
`endif

    int errors = 0;
    int checks = 0;

    hit_vector_scan #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_first (out_first),
        .out_last  (out_last),
        .out_any   (out_any)
`ifdef HIT_VECTOR_ACCUM_EN
        ,
        .accum_clr   (accum_clr),
        .total_count (total_count)
`endif
    );

    hit_vector_scan #(.WIDTH(40), .CHUNK(16)) dut40 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid40),
        .in_ready  (in_ready40),
        .in_vec    (in_vec40),
        .out_valid (out_valid40),
        .out_ready (out_ready40),
        .out_count (out_count40),
        .out_first (out_first40),
        .out_last  (out_last40),
        .out_any   (out_any40)
`ifdef HIT_VECTOR_ACCUM_EN
        ,
        .accum_clr   (accum_clr40),
        .total_count (total_count40)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one vector, checks it is accepted on the next edge, then scrambles in_vec.
    task automatic applyStimulus(input bit w40, input logic [63:0] v);
        if (w40) begin
            in_vec40   = v[39:0];
            in_valid40 = 1'b1;
            checkOutput("accept_ready40", {63'd0, in_ready40}, 64'd1);
        end else begin
            in_vec   = v;
            in_valid = 1'b1;
            checkOutput("accept_ready", {63'd0, in_ready}, 64'd1);
        end
        tick();
        in_valid   = 1'b0;
        in_valid40 = 1'b0;
        in_vec     = ~v;
        in_vec40   = ~v[39:0];
    endtask

    task automatic expectResult(input bit w40, input string tag, input int exp_lat,
                                input int cnt, input int first, input int last, input bit any);
        int lat;
        lat = 0;
        while (((w40 ? out_valid40 : out_valid) !== 1'b1) && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_count"}, w40 ? 64'(out_count40) : 64'(out_count), 64'(cnt));
        checkOutput({tag, "_first"}, w40 ? 64'(out_first40) : 64'(out_first), 64'(first));
        checkOutput({tag, "_last"},  w40 ? 64'(out_last40)  : 64'(out_last),  64'(last));
        checkOutput({tag, "_any"},   w40 ? 64'(out_any40)   : 64'(out_any),   64'(any));
    endtask

    initial begin
        logic seen;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_vec      = '0;
        out_ready   = 1'b1;
        in_valid40  = 1'b0;
        in_vec40    = '0;
        out_ready40 = 1'b1;
`ifdef HIT_VECTOR_ACCUM_EN
        accum_clr   = 1'b0;
        accum_clr40 = 1'b0;
`endif
        repeat (3) tick();
        $display("[TB] reset checks");
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_data", {44'd0, out_count, out_first, out_last, out_any}, 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] basic vectors");
        applyStimulus(0, 64'h00010000_00010000);
        expectResult(0, "t1", 4, 2, 16, 48, 1);
        tick();
        applyStimulus(0, 64'h01010010_00010001);
        expectResult(0, "t2", 4, 5, 0, 56, 1);
        tick();
        applyStimulus(0, 64'h0);
        expectResult(0, "zero", 4, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF);
        expectResult(0, "ones", 4, 64, 0, 63, 1);
        tick();

        $display("[TB] partial final chunk");
        applyStimulus(1, 64'hFF_FFFF_FFFF);
        expectResult(1, "w40_ones", 3, 40, 0, 39, 1);
        tick();
        applyStimulus(1, 64'h88_0000_0000);
        expectResult(1, "w40_top", 3, 2, 35, 39, 1);
        tick();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(0, 64'h80000000_00000002);
        expectResult(0, "bp", 4, 2, 1, 63, 1);
        in_vec   = 64'hF0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("hold_data", {44'd0, out_count, out_first, out_last, out_any},
                        {44'd0, 7'd2, 6'd1, 6'd63, 1'b1});
        end
        in_vec    = 64'h4;
        out_ready = 1'b1;
        tick();
        checkOutput("release_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("release_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("release_retain", {44'd0, out_count, out_first, out_last, out_any},
                    {44'd0, 7'd2, 6'd1, 6'd63, 1'b1});
        tick();
        checkOutput("next_accepted", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        in_vec   = '0;
        expectResult(0, "after_bp", 4, 1, 2, 2, 1);
        tick();

        $display("[TB] reset during scan");
        applyStimulus(0, 64'hFF);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        checkOutput("mid_rst_no_result", {63'd0, seen}, 64'd0);
        checkOutput("mid_rst_ready_after", {63'd0, in_ready}, 64'd1);
        checkOutput("mid_rst_count_cleared", 64'(out_count), 64'd0);
        applyStimulus(0, 64'h00010000_00010000);
        expectResult(0, "post_rst", 4, 2, 16, 48, 1);
        tick();

`ifdef HIT_VECTOR_ACCUM_EN
        $display("[TB] accumulator");
        accum_clr = 1'b1;
        tick();
        accum_clr = 1'b0;
        checkOutput("acc_clr0", 64'(total_count), 64'd0);
        applyStimulus(0, 64'h00010000_00010000);
        expectResult(0, "acc_a", 4, 2, 16, 48, 1);
        tick();
        applyStimulus(0, 64'h01010010_00010001);
        expectResult(0, "acc_b", 4, 5, 0, 56, 1);
        tick();
        checkOutput("acc_total", 64'(total_count), 64'd7);
        accum_clr = 1'b1;
        tick();
        accum_clr = 1'b0;
        checkOutput("acc_clr1", 64'(total_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
